// File: rtl/control_unit.sv
// Hardwired sequencer for the 8-bit IR/RegFile/ARF/ALU datapath.
// Optional single-step mode: define CU_SINGLE_STEP_EN.
module control_unit (
  input  logic        CLK,
  input  logic        Reset,
`ifdef CU_SINGLE_STEP_EN
  input  logic        Step,
`endif
  input  logic [15:0] IRout,
  input  logic [3:0]  ALUFlags,
  output logic        IR_LH,
  output logic        IR_En,
  output logic [1:0]  IR_FunSel,
  output logic [1:0]  ARF_OutASel,
  output logic [1:0]  ARF_OutBSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RegSel,
  output logic [2:0]  RF_O1Sel,
  output logic [2:0]  RF_O2Sel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        Mem_RD,
  output logic        Mem_WR,
  output logic [2:0]  SC,
  output logic        Halted
);

  localparam logic [3:0] ALU_AND = 4'b0111;

`ifdef CU_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_T0, S_T1, S_T2, S_T3, S_HALT, S_WAIT
  } state_t;
  localparam state_t S_DONE = S_WAIT;
`else
  typedef enum logic [2:0] {
    S_T0, S_T1, S_T2, S_T3, S_HALT
  } state_t;
  localparam state_t S_DONE = S_T0;
`endif

  state_t state, state_n;

  logic [3:0] op;
  logic [1:0] dst;
  logic [1:0] src1;
  logic [1:0] src2;
  logic [3:0] dst_en;
  logic       unused_flags;

  assign op     = IRout[15:12];
  assign dst    = IRout[11:10];
  assign src1   = IRout[9:8];
  assign src2   = IRout[7:6];
  assign dst_en = ~(4'b0001 << dst);
  assign unused_flags = ^ALUFlags[2:0];

  function automatic logic [3:0] alu_code(
    input logic [3:0] o
  );
    logic [3:0] c;
    c = 4'b0000;
    unique case (o)
      4'h0: c = ALU_AND;
      4'h1: c = 4'b1000;
      4'h2: c = 4'b0010;
      4'h3: c = 4'b0100;
      4'h4: c = 4'b0101;
      4'h5: c = 4'b1001;
      4'h6: c = 4'b1010;
      4'h7: c = 4'b1011;
      4'h8: c = 4'b1110;
      4'h9: c = 4'b1111;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  always_ff @(posedge CLK) begin
    if (Reset) state <= S_T0;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    IR_LH       = 1'b0;
    IR_En       = 1'b0;
    IR_FunSel   = 2'b01;
    ARF_OutASel = 2'b00;
    ARF_OutBSel = 2'b00;
    ARF_FunSel  = 2'b01;
    ARF_RegSel  = 4'b1111;
    RF_O1Sel    = 3'd0;
    RF_O2Sel    = 3'd0;
    RF_FunSel   = 2'b01;
    RF_RSel     = 4'b1111;
    RF_TSel     = 4'b1111;
    ALU_FunSel  = 4'b0001;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    Mem_RD      = 1'b0;
    Mem_WR      = 1'b0;
    SC          = 3'd0;
    Halted      = 1'b0;

    if (Reset) begin
      // Clear every datapath register on the same edge
      ARF_RegSel = 4'b0000;
      ARF_FunSel = 2'b00;
      RF_RSel    = 4'b0000;
      RF_TSel    = 4'b0000;
      RF_FunSel  = 2'b00;
      IR_En      = 1'b1;
      IR_FunSel  = 2'b00;
      state_n    = S_T0;
    end else begin
      unique case (state)
        S_T0, S_T1: begin
          ARF_OutBSel = 2'd3;
          Mem_RD      = 1'b1;
          IR_LH       = (state == S_T1);
          IR_En       = 1'b1;
          ARF_RegSel  = 4'b1110;
          ARF_FunSel  = 2'b11;
          SC          = (state == S_T1) ? 3'd1 : 3'd0;
          state_n     = (state == S_T1) ? S_T2 : S_T1;
        end
        S_T2: begin
          SC      = 3'd2;
          state_n = S_DONE;
          case (op)
            4'hA: begin
              MuxASel = 2'b10;
              RF_RSel = dst_en;
            end
            4'hB, 4'hC: begin
              MuxBSel    = 2'b10;
              ARF_RegSel = 4'b1101;
              state_n    = S_T3;
            end
            4'hD: begin
              MuxBSel    = 2'b10;
              ARF_RegSel = 4'b1110;
            end
            4'hE: begin
              if (!ALUFlags[3]) begin
                MuxBSel    = 2'b10;
                ARF_RegSel = 4'b1110;
              end
            end
            4'hF: state_n = S_HALT;
            default: begin
              RF_O1Sel   = {1'b1, src1};
              RF_O2Sel   = {1'b1, src2};
              ALU_FunSel = alu_code(op);
              RF_RSel    = dst_en;
            end
          endcase
        end
        S_T3: begin
          SC          = 3'd3;
          ARF_OutBSel = 2'd0;
          state_n     = S_DONE;
          if (op == 4'hB) begin
            Mem_RD  = 1'b1;
            MuxASel = 2'b01;
            RF_RSel = dst_en;
          end else if (op == 4'hC) begin
            // ALU passes the stored register through to memory
            RF_O1Sel   = {1'b1, dst};
            ALU_FunSel = 4'b0000;
            Mem_WR     = 1'b1;
          end
        end
        S_HALT: Halted = 1'b1;
`ifdef CU_SINGLE_STEP_EN
        S_WAIT: if (Step) state_n = S_T0;
`endif
        default: state_n = S_T0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomised bench for control_unit against a per-instruction
// timing model derived from the opcode table.
module tb_control_unit;

  typedef struct packed {
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_fs;
    logic [1:0] outa;
    logic [1:0] outb;
    logic [1:0] arf_fs;
    logic [3:0] regsel;
    logic [2:0] o1;
    logic [2:0] o2;
    logic [1:0] rf_fs;
    logic [3:0] rsel;
    logic [3:0] tsel;
    logic [3:0] alu;
    logic [1:0] muxa;
    logic [1:0] muxb;
    logic       rd;
    logic       wr;
    logic [2:0] sc;
    logic       halted;
  } cu_t;

  localparam logic [3:0] ALU_TAB [0:9] = '{
    4'h7, 4'h8, 4'h2, 4'h4, 4'h5,
    4'h9, 4'hA, 4'hB, 4'hE, 4'hF
  };

`ifdef CU_SINGLE_STEP_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Step;
  logic [15:0] IRout;
  logic [3:0]  ALUFlags;
  logic        IR_LH, IR_En;
  logic [1:0]  IR_FunSel;
  logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic [2:0]  RF_O1Sel, RF_O2Sel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  MuxASel, MuxBSel;
  logic        Mem_RD, Mem_WR;
  logic [2:0]  SC;
  logic        Halted;

  int nchk = 0;
  int nerr = 0;

  int m_k = 0;
  bit m_halt = 0;
  bit m_wait = 0;

  cu_t obs;

  always #5 CLK = ~CLK;

  control_unit dut (
    .CLK(CLK),
    .Reset(Reset),
`ifdef CU_SINGLE_STEP_EN
    .Step(Step),
`endif
    .IRout(IRout),
    .ALUFlags(ALUFlags),
    .IR_LH(IR_LH),
    .IR_En(IR_En),
    .IR_FunSel(IR_FunSel),
    .ARF_OutASel(ARF_OutASel),
    .ARF_OutBSel(ARF_OutBSel),
    .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel),
    .RF_O1Sel(RF_O1Sel),
    .RF_O2Sel(RF_O2Sel),
    .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel),
    .RF_TSel(RF_TSel),
    .ALU_FunSel(ALU_FunSel),
    .MuxASel(MuxASel),
    .MuxBSel(MuxBSel),
    .Mem_RD(Mem_RD),
    .Mem_WR(Mem_WR),
    .SC(SC),
    .Halted(Halted)
  );

  assign obs = '{
    ir_lh: IR_LH, ir_en: IR_En, ir_fs: IR_FunSel,
    outa: ARF_OutASel, outb: ARF_OutBSel,
    arf_fs: ARF_FunSel, regsel: ARF_RegSel,
    o1: RF_O1Sel, o2: RF_O2Sel, rf_fs: RF_FunSel,
    rsel: RF_RSel, tsel: RF_TSel, alu: ALU_FunSel,
    muxa: MuxASel, muxb: MuxBSel, rd: Mem_RD,
    wr: Mem_WR, sc: SC, halted: Halted
  };

  function automatic cu_t idle();
    cu_t e;
    e = '0;
    e.ir_fs  = 2'b01;
    e.arf_fs = 2'b01;
    e.rf_fs  = 2'b01;
    e.regsel = 4'hF;
    e.rsel   = 4'hF;
    e.tsel   = 4'hF;
    e.alu    = 4'b0001;
    return e;
  endfunction

  function automatic cu_t model(
    input bit rst, input bit hlt, input bit wt,
    input int k, input logic [15:0] ir,
    input logic [3:0] fl
  );
    cu_t e;
    int op, d, s1, s2;
    op = int'(ir[15:12]);
    d  = int'(ir[11:10]);
    s1 = int'(ir[9:8]);
    s2 = int'(ir[7:6]);
    e = idle();
    if (rst) begin
      e.regsel = 4'h0;
      e.arf_fs = 2'b00;
      e.rsel   = 4'h0;
      e.tsel   = 4'h0;
      e.rf_fs  = 2'b00;
      e.ir_en  = 1'b1;
      e.ir_fs  = 2'b00;
      return e;
    end
    if (hlt) begin
      e.halted = 1'b1;
      return e;
    end
    if (wt) return e;
    e.sc = 3'(k);
    if (k < 2) begin
      e.outb   = 2'd3;
      e.rd     = 1'b1;
      e.ir_lh  = (k == 1);
      e.ir_en  = 1'b1;
      e.regsel = 4'b1110;
      e.arf_fs = 2'b11;
    end else if (k == 2) begin
      if (op <= 9) begin
        e.alu = ALU_TAB[op];
        e.o1  = 3'(4 + s1);
        e.o2  = 3'(4 + s2);
        e.rsel[d] = 1'b0;
      end else if (op == 10) begin
        e.muxa = 2'b10;
        e.rsel[d] = 1'b0;
      end else if (op == 11 || op == 12) begin
        e.muxb = 2'b10;
        e.regsel = 4'b1101;
      end else if (op == 13 || (op == 14 && !fl[3])) begin
        e.muxb = 2'b10;
        e.regsel = 4'b1110;
      end
    end else begin
      e.outb = 2'd0;
      if (op == 11) begin
        e.rd   = 1'b1;
        e.muxa = 2'b01;
        e.rsel[d] = 1'b0;
      end else begin
        e.o1  = 3'(4 + d);
        e.alu = 4'b0000;
        e.wr  = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag);
    cu_t ex;
    ex = model(Reset, m_halt, m_wait, m_k, IRout, ALUFlags);
    nchk++;
    assert (obs === ex) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, ex);
    end
    nchk++;
    assert (!(Mem_RD && Mem_WR)) else begin
      nerr++;
      $error("FAIL %s_strobes: observed rd=%b wr=%b expected not both",
             tag, Mem_RD, Mem_WR);
    end
  endtask

  task automatic advance();
    int lat;
    lat = (IRout[15:12] == 4'hB || IRout[15:12] == 4'hC) ? 4 : 3;
    if (Reset) begin
      m_k = 0;
      m_halt = 0;
      m_wait = 0;
    end else if (m_halt) begin
      m_halt = 1;
    end else if (m_wait) begin
      m_wait = 0;
      m_k = 0;
    end else if (m_k == 2 && IRout[15:12] == 4'hF) begin
      m_halt = 1;
    end else if (m_k == lat - 1) begin
      m_k = 0;
      m_wait = SS;
    end else begin
      m_k++;
    end
  endtask

  task automatic cyc(input string tag);
    @(negedge CLK);
    check(tag);
    @(posedge CLK);
    #1;
    advance();
  endtask

  task automatic run_instr(
    input logic [15:0] ir, input logic [3:0] fl,
    input string tag
  );
    int n;
    IRout = ir;
    ALUFlags = fl;
    n = 0;
    do begin
      cyc(tag);
      n++;
    end while (!(m_k == 0 && !m_wait) && !m_halt && n < 8);
  endtask

  initial begin
    int hcnt;
    Reset = 1'b1;
    Step = 1'b1;
    IRout = 16'h0000;
    ALUFlags = 4'h0;
    @(posedge CLK);
    #1;
    cyc("reset0");
    cyc("reset1");
    Reset = 1'b0;
    run_instr(16'h3600, 4'h0, "add");
    run_instr(16'hB842, 4'h0, "ldm");
    run_instr(16'hE010, 4'b1000, "bne_z");
    run_instr(16'hE010, 4'b0000, "bne_nz");
    run_instr(16'hD0FF, 4'h0, "bra");
    run_instr(16'hAC7E, 4'h0, "ldi");
    run_instr(16'h2500, 4'h0, "not");
    run_instr(16'hC455, 4'h0, "stm");
    IRout = 16'hC455;
    cyc("stm_t0");
    cyc("stm_t1");
    cyc("stm_t2");
    Reset = 1'b1;
    cyc("stm_t3_reset");
    Reset = 1'b0;
    run_instr(16'h9BC0, 4'h0, "ror");
    run_instr(16'hF000, 4'h0, "hlt");
    for (int i = 0; i < 10; i++) cyc("halted");
    Reset = 1'b1;
    cyc("halt_reset");
    Reset = 1'b0;
    run_instr(16'h0E40, 4'h0, "and_after_halt");

    hcnt = 0;
    for (int c = 0; c < 1500; c++) begin
      if (m_halt && hcnt >= 3) Reset = 1'b1;
      else Reset = ($urandom_range(0, 39) == 0);
      if (m_k == 0 && !m_wait) IRout = 16'($urandom);
      ALUFlags = 4'($urandom);
      cyc("rand");
      hcnt = m_halt ? hcnt + 1 : 0;
    end
    Reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
